// File: rtl/sram_frame_writer_if.sv
// Write-stream, burst-control and SRAM-pin bundle for the frame-buffer writer.
// The writer takes the slave modport; the loader/top level takes the master modport.
interface sram_frame_writer_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              abort;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] words_written;
    logic              owns_bus;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_dq_oe;
    logic              CE;
    logic              UB;
    logic              LB;
    logic              OE;
    logic              WE;

    modport master (
        output start, base_addr, length, abort, wr_data, wr_valid,
        input  wr_ready, busy, done, words_written, owns_bus,
               sram_addr, sram_wdata, sram_dq_oe, CE, UB, LB, OE, WE
    );

    modport slave (
        input  start, base_addr, length, abort, wr_data, wr_valid,
        output wr_ready, busy, done, words_written, owns_bus,
               sram_addr, sram_wdata, sram_dq_oe, CE, UB, LB, OE, WE
    );
endinterface

// File: rtl/sram_frame_writer.sv
// Burst writer for the 1M x 16 async frame SRAM: stream words to consecutive
// addresses with a SETUP / WE-pulse / HOLD sequence per word.
module sram_frame_writer #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int WE_CYCLES = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    sram_frame_writer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DATA, S_SETUP, S_PULSE, S_HOLD, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [ADDR_W-1:0] r_len, w_len;
    logic [ADDR_W-1:0] r_count, w_count;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic [2:0]        r_pcnt, w_pcnt;
    logic              r_abort_seen, w_abort_seen;
    logic              r_active, r_done, r_wr_ready, r_dq_oe, r_we;

    always_comb begin
        w_next       = r_state;
        w_addr       = r_addr;
        w_len        = r_len;
        w_count      = r_count;
        w_wdata      = r_wdata;
        w_pcnt       = r_pcnt;
        w_abort_seen = r_abort_seen;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_addr  = bus.base_addr;
                    w_len   = bus.length;
                    w_count = '0;
                    w_next  = (bus.length == '0) ? S_DONE : S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                w_abort_seen = 1'b0;
                if (bus.wr_valid && r_wr_ready) begin
                    w_wdata = bus.wr_data;
                    w_next  = S_SETUP;
                end else if (bus.abort) begin
                    w_next = S_DONE;
                end
            end
            S_SETUP: begin
                w_abort_seen = bus.abort;
                w_pcnt       = 3'd1;
                w_next       = S_PULSE;
            end
            S_PULSE: begin
                // abort is only remembered here; the word in flight always completes
                w_abort_seen = r_abort_seen | bus.abort;
                if (r_pcnt >= 3'(WE_CYCLES)) w_next = S_HOLD;
                else                          w_pcnt = r_pcnt + 3'd1;
            end
            S_HOLD: begin
                w_count = r_count + ADDR_W'(1);
                w_addr  = r_addr + ADDR_W'(1);
                if (w_count == r_len || r_abort_seen || bus.abort) w_next = S_DONE;
                else                                               w_next = S_WAIT_DATA;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Pin-level outputs are registered from the next-state decode so SRAM
    // strobes never glitch and change exactly on the state transition.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_len        <= '0;
            r_count      <= '0;
            r_wdata      <= '0;
            r_pcnt       <= '0;
            r_abort_seen <= 1'b0;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
            r_wr_ready   <= 1'b0;
            r_dq_oe      <= 1'b0;
            r_we         <= 1'b1;
        end else begin
            r_state      <= w_next;
            r_addr       <= w_addr;
            r_len        <= w_len;
            r_count      <= w_count;
            r_wdata      <= w_wdata;
            r_pcnt       <= w_pcnt;
            r_abort_seen <= w_abort_seen;
            r_active     <= (w_next != S_IDLE);
            r_done       <= (w_next == S_DONE);
            r_wr_ready   <= (w_next == S_WAIT_DATA);
            r_dq_oe      <= (w_next == S_SETUP) || (w_next == S_PULSE) || (w_next == S_HOLD);
            r_we         <= (w_next != S_PULSE);
        end
    end

    // busy, bus ownership and SRAM output-disable all span exactly the non-IDLE states
    assign bus.busy          = r_active;
    assign bus.owns_bus      = r_active;
    assign bus.OE            = r_active;
    assign bus.done          = r_done;
    assign bus.wr_ready      = r_wr_ready;
    assign bus.sram_dq_oe    = r_dq_oe;
    assign bus.WE            = r_we;
    assign bus.words_written = r_count;
    assign bus.sram_addr     = r_addr;
    assign bus.sram_wdata    = r_wdata;
    assign bus.CE            = 1'b0;
    assign bus.UB            = 1'b0;
    assign bus.LB            = 1'b0;
endmodule
